// File: rtl/seq_pkg.sv
// ============================================================================
// seq_pkg : shared types and constants for the seq_gen / seq_det pair
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package seq_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } seq_state_t;

    localparam logic [3:0] DET_PATTERN = 4'b1011;
    localparam int         DET_LEN     = 4;

endpackage

`default_nettype wire

// File: rtl/seq_gen.sv
// ============================================================================
// seq_gen : serial pattern generator, MSB-first, with repeat count and abort
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module seq_gen
    import seq_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int REP_W   = 8
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic                         pat_valid,
    output logic                         pat_ready,
    input  logic [MAX_LEN-1:0]           pat_data,
    input  logic [$clog2(MAX_LEN+1)-1:0] pat_len,
    input  logic [REP_W-1:0]             pat_rep,
    input  logic                         abort,
    output logic                         ser_out,
    output logic                         ser_valid,
    output logic                         busy,
    output logic                         done
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int IDX_W = $clog2(MAX_LEN);

    seq_state_t         state_q, state_d;
    logic [MAX_LEN-1:0] sh_q, sh_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   len_m1_q, len_m1_d;
    logic [REP_W-1:0]   rep_left_q, rep_left_d;
    logic               ser_out_q, ser_out_d;
    logic               done_q, done_d;

    logic               accept;
    logic [LEN_W-1:0]   len_c;
    logic [IDX_W-1:0]   len_load;

    assign pat_ready = (state_q == IDLE) && nrst;
    assign accept    = pat_valid && pat_ready;
    assign len_c     = (pat_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : pat_len;
    // len_c - 1 always fits the index width once clamped; unused when len_c == 0
    assign len_load  = IDX_W'(len_c - LEN_W'(1));

    always_comb begin
        state_d    = state_q;
        sh_d       = sh_q;
        idx_d      = idx_q;
        len_m1_d   = len_m1_q;
        rep_left_d = rep_left_q;
        ser_out_d  = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    sh_d       = pat_data;
                    len_m1_d   = len_load;
                    idx_d      = len_load;
                    rep_left_d = pat_rep;
                    if (len_c == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d   = SEND;
                        ser_out_d = pat_data[len_load];
                    end
                end
            end
            SEND: begin
                if (abort) begin
                    state_d = IDLE;
                end else if ((idx_q == '0) && (rep_left_q == '0)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    // passes run back to back: wrap straight to the MSB
                    if (idx_q == '0) begin
                        idx_d      = len_m1_q;
                        rep_left_d = rep_left_q - REP_W'(1);
                    end else begin
                        idx_d = idx_q - IDX_W'(1);
                    end
                    ser_out_d = sh_q[idx_d];
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q    <= IDLE;
            sh_q       <= '0;
            idx_q      <= '0;
            len_m1_q   <= '0;
            rep_left_q <= '0;
            ser_out_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sh_q       <= sh_d;
            idx_q      <= idx_d;
            len_m1_q   <= len_m1_d;
            rep_left_q <= rep_left_d;
            ser_out_q  <= ser_out_d;
            done_q     <= done_d;
        end
    end

    assign ser_out   = ser_out_q;
    assign ser_valid = (state_q == SEND);
    assign busy      = (state_q == SEND);
    assign done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_gen.sv
// ============================================================================
// tb_seq_gen : directed self-checking bench for seq_gen
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_seq_gen;

    logic        clk = 1'b0;
    logic        nrst;
    logic        pat_valid;
    logic        pat_ready;
    logic [15:0] pat_data;
    logic [4:0]  pat_len;
    logic [7:0]  pat_rep;
    logic        abort;
    logic        ser_out;
    logic        ser_valid;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;

    seq_gen #(.MAX_LEN(16), .REP_W(8)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .pat_valid (pat_valid),
        .pat_ready (pat_ready),
        .pat_data  (pat_data),
        .pat_len   (pat_len),
        .pat_rep   (pat_rep),
        .abort     (abort),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a request and lets it be taken on the next edge
    task automatic req(input logic [15:0] d, input logic [4:0] l, input logic [7:0] r);
        pat_data  = d;
        pat_len   = l;
        pat_rep   = r;
        pat_valid = 1'b1;
        check_eq("req_ready", 32'(pat_ready), 32'd1);
        tick();
        pat_valid = 1'b0;
    endtask

    task automatic expect_stream(input string tag, input logic [63:0] bits, input int n);
        for (int k = 0; k < n; k++) begin
            check_eq({tag, "_valid"}, 32'(ser_valid), 32'd1);
            check_eq({tag, "_bit"},   32'(ser_out),   32'(bits[n-1-k]));
            check_eq({tag, "_busy"},  32'(busy),      32'd1);
            check_eq({tag, "_done"},  32'(done),      32'd0);
            check_eq({tag, "_ready"}, 32'(pat_ready), 32'd0);
            tick();
        end
    endtask

    task automatic expect_done(input string tag);
        check_eq({tag, "_done_hi"}, 32'(done),      32'd1);
        check_eq({tag, "_gap"},     32'(ser_valid), 32'd0);
        check_eq({tag, "_idle"},    32'(busy),      32'd0);
        check_eq({tag, "_rdy"},     32'(pat_ready), 32'd1);
        check_eq({tag, "_ser0"},    32'(ser_out),   32'd0);
    endtask

    task automatic finish_xfer(input string tag);
        expect_done(tag);
        tick();
        check_eq({tag, "_done_lo"}, 32'(done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        nrst      = 1'b0;
        pat_valid = 1'b0;
        pat_data  = '0;
        pat_len   = '0;
        pat_rep   = '0;
        abort     = 1'b0;

        // reset state
        tick();
        tick();
        check_eq("rst_valid", 32'(ser_valid), 32'd0);
        check_eq("rst_busy",  32'(busy),      32'd0);
        check_eq("rst_done",  32'(done),      32'd0);
        check_eq("rst_ser",   32'(ser_out),   32'd0);
        check_eq("rst_ready", 32'(pat_ready), 32'd0);
        nrst = 1'b1;
        #1;
        check_eq("rel_ready", 32'(pat_ready), 32'd1);

        // basic single pass
        req(16'b1011, 5'd4, 8'd0);
        expect_stream("basic", 64'b1011, 4);
        finish_xfer("basic");

        // three contiguous passes
        req(16'b1011, 5'd4, 8'd2);
        expect_stream("rep", 64'b101110111011, 12);
        finish_xfer("rep");

        // abort mid-transfer; abort raised with the request is ignored in IDLE
        abort = 1'b1;
        req(16'b1011, 5'd4, 8'd0);
        abort = 1'b0;
        expect_stream("abt_pre", 64'b10, 2);
        check_eq("abt_bit2", 32'(ser_out), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_eq("abt_valid", 32'(ser_valid), 32'd0);
        check_eq("abt_busy",  32'(busy),      32'd0);
        check_eq("abt_ready", 32'(pat_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check_eq("abt_nodone", 32'(done), 32'd0);
            tick();
        end
        req(16'b0110, 5'd4, 8'd0);
        expect_stream("post_abt", 64'b0110, 4);
        finish_xfer("post_abt");

        // abort coinciding with the last bit suppresses done
        req(16'b1101, 5'd4, 8'd0);
        expect_stream("abl", 64'b110, 3);
        check_eq("abl_last", 32'(ser_out), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_eq("abl_done",  32'(done),      32'd0);
        check_eq("abl_valid", 32'(ser_valid), 32'd0);
        tick();
        check_eq("abl_done2", 32'(done), 32'd0);

        // zero length
        req(16'hFFFF, 5'd0, 8'd3);
        check_eq("len0_valid", 32'(ser_valid), 32'd0);
        check_eq("len0_busy",  32'(busy),      32'd0);
        check_eq("len0_done",  32'(done),      32'd1);
        check_eq("len0_ready", 32'(pat_ready), 32'd1);
        tick();
        check_eq("len0_done_lo", 32'(done),      32'd0);
        check_eq("len0_valid2",  32'(ser_valid), 32'd0);

        // full length and clamped length
        req(16'hA5C3, 5'd16, 8'd0);
        expect_stream("max", 64'hA5C3, 16);
        finish_xfer("max");
        req(16'h3C5A, 5'd31, 8'd0);
        expect_stream("clamp", 64'h3C5A, 16);
        finish_xfer("clamp");

        // reset during a transfer, with a new request held through reset
        req(16'b1011, 5'd4, 8'd0);
        expect_stream("mrst_pre", 64'b101, 3);
        nrst      = 1'b0;
        pat_data  = 16'b1001;
        pat_len   = 5'd4;
        pat_rep   = 8'd0;
        pat_valid = 1'b1;
        tick();
        check_eq("mrst_valid", 32'(ser_valid), 32'd0);
        check_eq("mrst_busy",  32'(busy),      32'd0);
        check_eq("mrst_done",  32'(done),      32'd0);
        check_eq("mrst_ready", 32'(pat_ready), 32'd0);
        tick();
        check_eq("mrst_hold",  32'(ser_valid), 32'd0);
        nrst = 1'b1;
        #1;
        check_eq("mrst_rel_ready", 32'(pat_ready), 32'd1);
        check_eq("mrst_rel_done",  32'(done),      32'd0);
        tick();
        pat_valid = 1'b0;
        expect_stream("mrst_post", 64'b1001, 4);
        finish_xfer("mrst_post");

        // back-to-back with pat_valid held high
        pat_data  = 16'b1101;
        pat_len   = 5'd4;
        pat_rep   = 8'd0;
        pat_valid = 1'b1;
        tick();
        pat_data = 16'b0111;
        expect_stream("b2b_a", 64'b1101, 4);
        expect_done("b2b_a");
        tick();
        pat_valid = 1'b0;
        expect_stream("b2b_b", 64'b0111, 4);
        finish_xfer("b2b_b");

        // full repeat range: 256 passes of a 2-bit pattern
        req(16'b10, 5'd2, 8'd255);
        for (int k = 0; k < 512; k++) begin
            check_eq("maxrep_valid", 32'(ser_valid), 32'd1);
            check_eq("maxrep_bit",   32'(ser_out),   ((k % 2) == 0) ? 32'd1 : 32'd0);
            tick();
        end
        finish_xfer("maxrep");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seq_gen.md
# seq_gen

Serial pattern generator: the transmit-side counterpart of the `seq_det` sequence detector. It accepts a pattern word, its bit length and a repeat count over a valid/ready handshake. It then drives the pattern MSB-first onto a one-bit serial line, one bit per clock. It sits in front of `seq_det`, or any serial-bit consumer, as a stimulus and traffic source.

## Interface
Parameters:
- MAX_LEN, 16, maximum pattern length in bits (≥2)
- REP_W, 8, width of the repeat-count field

Ports:
- clk  in  1  clock, all logic on posedge
- nrst  in  1  reset, synchronous, active-low
- pat_valid  in  1  pattern request valid
- pat_ready  out  1  generator can accept a request
- pat_data  in  MAX_LEN  pattern; bit pat_len-1 is sent first
- pat_len  in  $clog2(MAX_LEN+1)  pattern length in bits (0..MAX_LEN)
- pat_rep  in  REP_W  extra repetitions; total passes = pat_rep+1
- abort  in  1  terminate current transfer
- ser_out  out  1  serial bit
- ser_valid  out  1  ser_out carries a pattern bit this cycle
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse on normal completion

## Operation
- Handshake: a request is accepted at a posedge where pat_valid && pat_ready. pat_data, pat_len and pat_rep are captured into internal registers on that edge; inputs are don't-care afterwards.
- pat_ready = (state == IDLE) && nrst; deasserted throughout SEND.
- States: IDLE, SEND.
  - IDLE -> SEND on an accepted request with pat_len ≠ 0.
  - SEND -> IDLE after the last bit, or on abort.
- pat_len = 0: the request is accepted and stays in IDLE; done pulses next cycle; no ser_valid.
- pat_len > MAX_LEN: clamped to MAX_LEN.
- Datapath: shift register sh[MAX_LEN-1:0], bit index idx (counts pat_len-1 down to 0), repeat counter rep_left (loaded with pat_rep).
  - ser_out = captured pattern bit [idx].
  - When idx hits 0 and rep_left ≠ 0: idx reloads to len-1 and rep_left decrements. Passes are contiguous, with no gap bit.
  - The last bit is the bit sent with idx == 0 && rep_left == 0.
- abort:
  - Sampled only in SEND; ignored in IDLE.
  - On an abort edge in SEND: the next cycle has ser_valid = 0 and busy = 0, the state is IDLE, and done is not pulsed.
  - Abort on the same edge as the last bit: abort wins, and no done is pulsed.
- ser_out = 0 whenever ser_valid = 0.
- busy = (state == SEND).

## Timing
- Reset: while nrst = 0 at a posedge, the next-cycle values are state IDLE, ser_out 0, ser_valid 0, busy 0, done 0. pat_ready = 0 while nrst is low.
- Reset mid-SEND discards the transfer with no done pulse. A pat_valid held through reset is not accepted until the first edge with nrst = 1.
- Latency: for a request accepted at edge T, the first bit appears on ser_out/ser_valid in cycle T+1 (registered output). Bit k (0-based) appears in cycle T+1+k.
- Total bits N = len·(pat_rep+1). ser_valid is high for exactly cycles T+1..T+N.
- done is high in cycle T+N+1 only, coincident with pat_ready = 1.
- Back-to-back: a request accepted at edge T+N+1 (during the done cycle) starts its first bit in cycle T+N+2. This gives a minimum one-cycle ser_valid gap between transfers.
- Repeat counter: the full REP_W range is valid. pat_rep = 2^REP_W−1 yields 2^REP_W passes, with no overflow.

## Structure
- Shared package `seq_pkg`:
  - state enum type `seq_state_t` {IDLE, SEND};
  - constants DET_PATTERN = 4'b1011 and DET_LEN = 4, shared with `seq_det` and benches.
- Flat implementation: one FSM always_ff plus the datapath registers. No sub-module; the shift/index logic is too small to justify one.

## Test plan
- Basic send: after reset, drive pat_data = 'b1011, pat_len = 4, pat_rep = 0, accepted at edge T.
  - ser_out = 1,0,1,1 with ser_valid = 1 in cycles T+1..T+4.
  - done = 1 in T+5 only; busy high T+1..T+4.
- Repeats: pattern 1011, pat_len = 4, pat_rep = 2.
  - 12 contiguous bits 101110111011 with no ser_valid gap.
  - A single done pulse after bit 12.
- Abort: pattern 1011, pat_len = 4, abort asserted during the cycle carrying bit 2.
  - ser_valid = 0 in the following cycle; done never pulses; pat_ready = 1.
  - A new request is then accepted and sent correctly.
- Edge lengths:
  - pat_len = 0: accepted, done pulses next cycle, no ser_valid.
  - pat_len = MAX_LEN with pat_data = 'hA5C3: 16 bits sent MSB-first.
  - pat_len = MAX_LEN+… (clamped): behaves as MAX_LEN.
- Reset mid-SEND: nrst = 0 during bit 3.
  - Next cycle: ser_valid = busy = done = 0; pat_ready = 0 while nrst is low.
  - After release, a request held on pat_valid is accepted on the first edge with nrst = 1.
- Back-to-back: pat_valid held high with two queued 4-bit requests.
  - The second request is accepted in the done cycle of the first.
  - Exactly one ser_valid = 0 cycle separates the two transfers.
